muldiv_seq: RTL
===============

# muldiv_seq

Iterative RV32M multiply/divide sequencer attached to the EXECUTE stage. It accepts one M-extension operation from the execute pipeline register with already-forwarded operands. It computes the result over 32 cycles using a single shared 33-bit adder/subtractor, and holds the pipeline via a stall request until the result is ready. Divide-by-zero and signed overflow bypass the iteration and complete immediately.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  EXECUTE holds a valid M-extension instruction.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a  in  32  forwarded rs1 value (dividend / multiplicand).
- src_b  in  32  forwarded rs2 value (divisor / multiplier).
- kill  in  1  flush of EXECUTE; aborts any operation in progress.
- hold  in  1  downstream stall; EXECUTE cannot retire this cycle.
- stall_md  out  1  to the hazard unit; stalls FETCH/DECODE/EXECUTE.
- result  out  32  final result, valid when done=1.
- done  out  1  result valid this cycle.

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE, cnt=0, all datapath registers 0.
- IDLE, start=1, kill=0:
  - Latch op, operand signs and magnitudes (abs taken only for signed operands of the op).
  - For MULHSU, only src_a is signed.
  - Go to BUSY with cnt=0.
  - Special case: DIV/DIVU/REM/REMU with src_b=0, or DIV/REM with src_a=0x80000000 and src_b=0xFFFFFFFF, loads the final result directly and goes to DONE.
- BUSY, multiply: radix-2 shift-add. Each cycle, if multiplier LSB=1, add multiplicand to the upper 33 bits of the 64-bit accumulator, then shift right 1.
- BUSY, divide: restoring division. Shift {rem,quot} left 1; subtract divisor from the 33-bit remainder. If non-negative, keep the difference and set quotient LSB=1; else restore.
- Only one 33-bit adder is instantiated and shared between both modes.
- cnt increments each BUSY cycle. At cnt=31 the final iteration completes; go to DONE.
- DONE: result is driven from registered final values:
  - MUL: low word.
  - MULH/MULHSU/MULHU: high word, 64-bit negated when signs differ.
  - DIV/DIVU: quotient, negated if sa^sb (signed ops).
  - REM/REMU: remainder, negated if sa (signed ops).
- Special-case results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=src_a.
  - Overflow: quotient=0x80000000, remainder=0.
- DONE with hold=0: go to IDLE. DONE with hold=1: stay in DONE, result and done stable.
- kill in any state: next state IDLE and done drops, regardless of start or hold. A start coincident with kill is ignored.
- start in BUSY or DONE is ignored. EXECUTE contents are frozen by the stall, so the same instruction is not re-issued.

## Timing
- stall_md = (IDLE & start & ~kill) | BUSY. It is combinational and deasserted in DONE, so the instruction retires on the DONE cycle.
- done = (state==DONE), registered-state output. result is held constant while done=1.
- Normal latency: start seen in cycle 0, BUSY cycles 1..32, DONE in cycle 33. stall_md is high in cycles 0..32.
- Special-case latency: start in cycle 0, DONE in cycle 1. stall_md is high in cycle 0 only.
- Back-to-back: a new start is sampled in the cycle after DONE (state IDLE); there is no dead cycle beyond that.
- Async reset mid-operation: immediate return to IDLE; stall_md=0, done=0, result=0.
- Operand ports are sampled only in IDLE on acceptance. Later changes to src_a/src_b (forwarding updates) have no effect.

## Test plan
- MUL 7×6, then MULHU 0xFFFFFFFF×0xFFFFFFFF:
  - First op: stall_md high cycles 0..32, done in cycle 33, result=42.
  - Second op: result=0xFFFFFFFE.
- MULH 0xFFFFFFFE(−2)×3 → result=0xFFFFFFFF. MULHSU 0xFFFFFFFF×2 → result=0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Corner cases, each with done in cycle 1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- kill at BUSY cycle 10 → IDLE next cycle, stall_md=0, no done. A following start of DIVU 9/3 completes normally with result=3.
- hold=1 for 3 cycles during DONE: done and result stable for 4 cycles, then IDLE. Reset asserted mid-BUSY: all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EXECUTE stage.
// A single shared 33-bit adder does one shift-add or restoring-divide step per cycle.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            kill,
   input  logic            hold,
   output logic            stall_md,
   output logic [XLEN-1:0] result,
   output logic            done
);

   localparam int CW = $clog2(XLEN);
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
      return '0 - x;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_d(input logic [2*XLEN-1:0] x);
      return '0 - x;
   endfunction

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic                sa_q, sa_d, sb_q, sb_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;

   logic signed [XLEN-1:0] a_s, b_s;
   logic                a_sgn, b_sgn, accept;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [XLEN:0]       add_a, add_b, add_y;
   logic                add_sub;
   logic [2*XLEN-1:0]   mul_step, div_step, prod_s;

   assign a_s    = src_a;
   assign b_s    = src_b;
   assign a_sgn  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   assign b_sgn  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   assign a_mag  = (a_sgn && a_s < 0) ? neg_w(src_a) : src_a;
   assign b_mag  = (b_sgn && b_s < 0) ? neg_w(src_b) : src_b;
   assign accept = (state_q == IDLE) && start && !kill;

   // The one adder: accumulate in multiply mode, trial-subtract in divide mode.
   always_comb begin
      add_sub = 1'b0;
      add_a   = {1'b0, acc_q[2*XLEN-1:XLEN]};
      add_b   = acc_q[0] ? {1'b0, mcand_q} : '0;
      if (op_q[2]) begin
         add_sub = 1'b1;
         add_a   = acc_q[2*XLEN-1:XLEN-1];
         add_b   = {1'b0, mcand_q};
      end
   end

   assign add_y    = add_a + (add_b ^ {(XLEN+1){add_sub}}) + {{XLEN{1'b0}}, add_sub};
   assign mul_step = {add_y, acc_q[XLEN-1:1]};
   assign div_step = add_y[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {add_y[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = op;
               cnt_d   = '0;
               sa_d    = a_sgn && a_s < 0;
               sb_d    = b_sgn && b_s < 0;
               state_d = BUSY;
               if (op[2]) begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  mcand_d = b_mag;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  mcand_d = a_mag;
               end
               // Special cases store the raw {rem, quot} with signs cleared so no fix-up applies.
               if (op[2] && src_b == '0) begin
                  acc_d   = {src_a, {XLEN{1'b1}}};
                  sa_d    = 1'b0;
                  sb_d    = 1'b0;
                  state_d = DONE;
               end else if (op[2] && !op[0] && src_a == {1'b1, {(XLEN-1){1'b0}}} && src_b == '1) begin
                  acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                  sa_d    = 1'b0;
                  sb_d    = 1'b0;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = op_q[2] ? div_step : mul_step;
            if (cnt_q == CW'(XLEN-1)) state_d = DONE;
         end
         DONE: begin
            if (!hold) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (kill) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         acc_q   <= '0;
         mcand_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
      end
   end

   assign prod_s   = (sa_q ^ sb_q) ? neg_d(acc_q) : acc_q;
   assign stall_md = accept || (state_q == BUSY);
   assign done     = (state_q == DONE);

   always_comb begin
      result = '0;
      if (state_q == DONE) begin
         case (op_q)
            OP_MUL:                       result = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = (sa_q ^ sb_q) ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
            default:                      result = sa_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
         endcase
      end
   end

endmodule
